// File: rtl/comparador_spwm_pkg.sv
// Shared types and constants for the SPWM comparator.
// Dead-time FSM states and sine index geometry.
package comparador_spwm_pkg;

  localparam int IDX_W      = 15;
  localparam int INDICE_MAX = 15359;

  typedef enum logic [2:0] {
    APAGADO,
    L_ON,
    MUERTO_LH,
    H_ON,
    MUERTO_HL
  } estado_t;

endpackage

// File: rtl/comparador_spwm_if.sv
// Sine ROM bus: index address out, amplitude back.
// rom_data is valid a fixed latency after rom_addr.
interface comparador_spwm_if
  import comparador_spwm_pkg::*;
#(
  parameter int CARRIER_W = 10
) ();

  logic [IDX_W-1:0]     rom_addr;
  logic [CARRIER_W-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/comparador_spwm_portadora_triangular.sv
// Symmetric triangle carrier 0..CARRIER_MAX..0.
// valle pulses the cycle after the carrier sits at zero.
module portadora_triangular
  import comparador_spwm_pkg::*;
#(
  parameter int CARRIER_W   = 10,
  parameter int CARRIER_MAX = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CARRIER_W-1:0] carrier,
  output logic                 valle
);

  localparam logic [CARRIER_W-1:0] TOP =
    CARRIER_W'(CARRIER_MAX);

  logic dir_up;
  logic subir;

  // Turn around at both ends in the same cycle the end is seen.
  assign subir = (carrier == '0) |
                 (dir_up & (carrier != TOP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carrier <= '0;
      dir_up  <= 1'b1;
      valle   <= 1'b0;
    end else if (!en) begin
      carrier <= '0;
      dir_up  <= 1'b1;
      valle   <= 1'b0;
    end else begin
      carrier <= subir ? carrier + 1'b1
                       : carrier - 1'b1;
      dir_up  <= subir;
      valle   <= (carrier == '0);
    end
  end

endmodule

// File: rtl/comparador_spwm.sv
// Sine-triangle PWM comparator with ROM fetch at each
// carrier valley and a dead-time complementary gate pair.
module comparador_spwm
  import comparador_spwm_pkg::*;
#(
  parameter int CARRIER_W   = 10,
  parameter int CARRIER_MAX = 1023,
  parameter int ROM_LAT     = 1,
  parameter int DEAD_CYCLES = 8,
  parameter int DEAD_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IDX_W-1:0]     i,
  comparador_spwm_if.master    rom,
  output logic                 valle,
  output logic                 pwm_h,
  output logic                 pwm_l
);

  localparam logic [CARRIER_W-1:0] TOP =
    CARRIER_W'(CARRIER_MAX);
  localparam logic [DEAD_W-1:0] DEAD_INI =
    DEAD_W'(DEAD_CYCLES - 1);

  logic [CARRIER_W-1:0] carrier;
  logic [CARRIER_W-1:0] ref_q;
  logic [CARRIER_W-1:0] dato_sat;
  logic [ROM_LAT-1:0]   pend;
  logic                 muestra;
  logic                 raw;
  estado_t              estado, estado_sig;
  logic [DEAD_W-1:0]    cnt, cnt_sig;

  portadora_triangular #(
    .CARRIER_W   (CARRIER_W),
    .CARRIER_MAX (CARRIER_MAX)
  ) u_portadora (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .carrier (carrier),
    .valle   (valle)
  );

  assign muestra  = en & (carrier == '0);
  assign dato_sat = (rom.rom_data > TOP) ? TOP
                                         : rom.rom_data;

  // pend marks the cycle whose rom_data answers the last address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom.rom_addr <= '0;
      pend         <= '0;
      ref_q        <= '0;
      raw          <= 1'b0;
    end else begin
      if (muestra) rom.rom_addr <= i;
      pend <= ROM_LAT'({pend, muestra});
      if (pend[ROM_LAT-1]) ref_q <= dato_sat;
      raw <= (ref_q > carrier);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= APAGADO;
      cnt    <= '0;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      estado <= estado_sig;
      cnt    <= cnt_sig;
      pwm_h  <= (estado_sig == H_ON);
      pwm_l  <= (estado_sig == L_ON);
    end
  end

  always_comb begin
    estado_sig = estado;
    cnt_sig    = cnt;
    if (!en) begin
      estado_sig = APAGADO;
    end else begin
      unique case (estado)
        APAGADO: estado_sig = L_ON;
        L_ON: begin
          if (raw) begin
            estado_sig = MUERTO_LH;
            cnt_sig    = DEAD_INI;
          end
        end
        MUERTO_LH: begin
          if (!raw)            estado_sig = L_ON;
          else if (cnt == '0)  estado_sig = H_ON;
          else                 cnt_sig = cnt - 1'b1;
        end
        H_ON: begin
          if (!raw) begin
            estado_sig = MUERTO_HL;
            cnt_sig    = DEAD_INI;
          end
        end
        MUERTO_HL: begin
          if (raw)             estado_sig = H_ON;
          else if (cnt == '0)  estado_sig = L_ON;
          else                 cnt_sig = cnt - 1'b1;
        end
        default: estado_sig = APAGADO;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_spwm.sv
// Random and directed bench for comparador_spwm against a
// phase-based behavioural model of carrier, fetch and gates.
module tb_comparador_spwm;
  import comparador_spwm_pkg::*;

  localparam int CW   = 10;
  localparam int CMAX = 15;
  localparam int DEAD = 2;
  localparam int PER  = 2 * CMAX;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic [14:0]   i_idx = '0;
  logic          valle;
  logic          pwm_h;
  logic          pwm_l;
  logic [CW-1:0] rom_mem [0:32767];

  int checks = 0;
  int errors = 0;
  bit seen;

  comparador_spwm_if #(.CARRIER_W(CW)) bus ();

  assign bus.rom_data = rom_mem[bus.rom_addr];

  comparador_spwm #(
    .CARRIER_W   (CW),
    .CARRIER_MAX (CMAX),
    .ROM_LAT     (1),
    .DEAD_CYCLES (DEAD),
    .DEAD_W      (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .i     (i_idx),
    .rom   (bus),
    .valle (valle),
    .pwm_h (pwm_h),
    .pwm_l (pwm_l)
  );

  always #5 clk = ~clk;

  // Model: carrier is a closed-form function of phase since enable.
  int          ph      = 0;
  bit          m_valle = 0;
  logic [14:0] m_addr  = '0;
  bit          m_pend  = 0;
  int          m_ref   = 0;
  bit          m_raw   = 0;
  bit          m_on    = 0;
  int          m_side  = 0;
  int          m_wait  = 0;

  function automatic int tri_val(int p);
    return (p <= CMAX) ? p : PER - p;
  endfunction

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; m_valle <= 0; m_addr <= '0; m_pend <= 0;
      m_ref <= 0; m_raw <= 0; m_on <= 0;
      m_side <= 0; m_wait <= 0;
    end else begin
      if (!en) begin
        m_on <= 0;
      end else if (!m_on) begin
        m_on <= 1; m_side <= 0; m_wait <= 0;
      end else if (m_wait == 0) begin
        if (int'(m_raw) != m_side) m_wait <= 1;
      end else if (int'(m_raw) == m_side) begin
        m_wait <= 0;
      end else if (m_wait == DEAD) begin
        m_side <= int'(m_raw); m_wait <= 0;
      end else begin
        m_wait <= m_wait + 1;
      end
      m_raw <= (m_ref > tri_val(ph));
      if (m_pend) m_ref <= sat(int'(rom_mem[m_addr]));
      m_pend  <= en && (tri_val(ph) == 0);
      m_valle <= en && (tri_val(ph) == 0);
      if (en && tri_val(ph) == 0) m_addr <= i_idx;
      ph <= en ? (ph + 1) % PER : 0;
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valle", valle, m_valle);
    chk("rom_addr", bus.rom_addr, m_addr);
    chk("carrier", dut.carrier, tri_val(ph));
    chk("pwm_h", pwm_h,
        m_on && m_wait == 0 && m_side == 1);
    chk("pwm_l", pwm_l,
        m_on && m_wait == 0 && m_side == 0);
    chk("overlap", pwm_h & pwm_l, 0);
  end

  task automatic wait_h(input bit lvl, string nm);
    seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = (pwm_h == lvl);
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) begin
      case ($urandom_range(0, 5))
        0: rom_mem[a] = CW'(0);
        1: rom_mem[a] = CW'(1);
        2: rom_mem[a] = CW'(15);
        3: rom_mem[a] = CW'(1000);
        4: rom_mem[a] = CW'($urandom_range(0, 15));
        default: rom_mem[a] = CW'($urandom_range(0, 1023));
      endcase
    end
    rom_mem[100] = CW'(8);

    repeat (3) @(negedge clk);
    chk("rst_pwm_h", pwm_h, 0);
    chk("rst_pwm_l", pwm_l, 0);
    chk("rst_valle", valle, 0);

    rst = 1'b0; en = 1'b1; i_idx = 15'd100;
    @(negedge clk);
    chk("e1_valle", valle, 1);
    chk("e1_addr", bus.rom_addr, 100);
    chk("e1_pwm_l", pwm_l, 1);
    @(negedge clk);
    chk("e2_valle", valle, 0);
    chk("e2_ref", dut.ref_q, 8);
    @(negedge clk);
    chk("e3_pwm_l", pwm_l, 1);
    @(negedge clk);
    chk("e4_pwm_l", pwm_l, 0);
    chk("e4_pwm_h", pwm_h, 0);
    @(negedge clk);
    chk("e5_both", {pwm_h, pwm_l}, 0);
    @(negedge clk);
    chk("e6_pwm_h", pwm_h, 1);
    repeat (25) @(negedge clk);
    chk("e31_valle", valle, 1);

    // en dropped while the high side conducts
    wait_h(1, "wait_h_on");
    en = 1'b0;
    @(negedge clk);
    chk("off_gates", {pwm_h, pwm_l}, 0);
    chk("off_carrier", dut.carrier, 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_pwm_l", pwm_l, 1);

    // asynchronous reset with the high gate on
    wait_h(1, "wait_h_rst");
    #2 rst = 1'b1;
    #1 chk("arst_gates", {pwm_h, pwm_l}, 0);
    chk("arst_carrier", dut.carrier, 0);
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset in the high-to-low dead band
    wait_h(1, "wait_h_dead");
    wait_h(0, "wait_hl_dead");
    chk("in_dead", dut.estado, MUERTO_HL);
    #2 rst = 1'b1;
    #1 chk("arst_state", dut.estado, APAGADO);
    chk("arst_cnt", dut.cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      i_idx = 15'($urandom_range(0, INDICE_MAX));
      if ($urandom_range(0, 299) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        en = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
